// File: rtl/planta_envase_pkg.sv
// Shared definitions for the bottling station and its process controller:
// one-hot state bit positions, default phase durations, timer sizing helper.
package planta_envase_pkg;

  localparam int unsigned IDX_VAZIO       = 0;
  localparam int unsigned IDX_MOVENDO     = 1;
  localparam int unsigned IDX_POSICIONADA = 2;
  localparam int unsigned IDX_ENCHENDO    = 3;
  localparam int unsigned IDX_CHEIA       = 4;
  localparam int unsigned IDX_VEDANDO     = 5;
  localparam int unsigned N_STATES        = 6;

  localparam int T_MOTOR_DEF = 4;
  localparam int T_FILL_DEF  = 8;
  localparam int T_SEAL_DEF  = 2;

  typedef enum logic [N_STATES-1:0] {
    VAZIO       = 6'b000001 << IDX_VAZIO,
    MOVENDO     = 6'b000001 << IDX_MOVENDO,
    POSICIONADA = 6'b000001 << IDX_POSICIONADA,
    ENCHENDO    = 6'b000001 << IDX_ENCHENDO,
    CHEIA       = 6'b000001 << IDX_CHEIA,
    VEDANDO     = 6'b000001 << IDX_VEDANDO
  } estado_t;

  function automatic int tmr_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/planta_envase_temporizador.sv
// Shared phase timer: synchronous clear has priority over count enable.
module temporizador #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 1'b1;
  end

endmodule

// File: rtl/planta_envase.sv
// Bottling station: move, fill and seal one bottle at a time, counting sealed
// bottles and freezing on any illegal command until reset.
module planta_envase
  import planta_envase_pkg::*;
#(
  parameter int T_MOTOR = T_MOTOR_DEF,
  parameter int T_FILL  = T_FILL_DEF,
  parameter int T_SEAL  = T_SEAL_DEF,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             M,
  input  logic             EV,
  input  logic             VE,
  output logic             presenca,
  output logic             cheia,
  output logic             vedada,
  output logic [CNT_W-1:0] contador,
  output logic             erro,
  output logic [5:0]       state
);

  localparam int TW = tmr_width(T_MOTOR, T_FILL, T_SEAL);
  // The entry edge counts as the first command cycle, so a phase ends when
  // the timer is about to reach T-1.
  localparam logic [TW-1:0] LAST_MOTOR = TW'(T_MOTOR - 2);
  localparam logic [TW-1:0] LAST_FILL  = TW'(T_FILL - 2);
  localparam logic [TW-1:0] LAST_SEAL  = TW'(T_SEAL - 2);

  estado_t       state_q, state_d;
  logic [TW-1:0] timer;
  logic          ilegal, congelado, selado, cmd, tmr_clr, tmr_en;

  always_comb begin
    ilegal = (M & EV) | (M & VE) | (EV & VE);
    if (EV && !(state_q inside {POSICIONADA, ENCHENDO})) ilegal = 1'b1;
    if (VE && !(state_q inside {CHEIA, VEDANDO}))        ilegal = 1'b1;
    if (M && (state_q inside {ENCHENDO, CHEIA, VEDANDO})) ilegal = 1'b1;
  end

  assign congelado = erro | ilegal;

  always_comb begin
    state_d = state_q;
    selado  = 1'b0;
    cmd     = 1'b0;
    if (!congelado) begin
      unique case (state_q)
        VAZIO:       if (M) state_d = MOVENDO;
        MOVENDO: begin
          cmd = M;
          if (M && timer == LAST_MOTOR) state_d = POSICIONADA;
        end
        POSICIONADA: begin
          if (EV)     state_d = ENCHENDO;
          else if (M) state_d = MOVENDO;
        end
        ENCHENDO: begin
          cmd = EV;
          if (EV && timer == LAST_FILL) state_d = CHEIA;
        end
        CHEIA:       if (VE) state_d = VEDANDO;
        VEDANDO: begin
          cmd = VE;
          if (VE && timer == LAST_SEAL) begin
            state_d = VAZIO;
            selado  = 1'b1;
          end
        end
        default:     state_d = VAZIO;
      endcase
    end
    tmr_clr = (state_d != state_q);
    tmr_en  = cmd & ~tmr_clr;
  end

  temporizador #(.W(TW)) u_temporizador (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .count (timer)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= VAZIO;
      presenca <= 1'b0;
      cheia    <= 1'b0;
      vedada   <= 1'b0;
      contador <= '0;
      erro     <= 1'b0;
    end else begin
      state_q  <= state_d;
      presenca <= state_d inside {POSICIONADA, ENCHENDO, CHEIA, VEDANDO};
      cheia    <= state_d inside {CHEIA, VEDANDO};
      vedada   <= selado;
      if (selado) contador <= contador + 1'b1;
      erro     <= erro | ilegal;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_planta_envase.sv
// Directed plus randomized bench for planta_envase against a phase/progress model.
module tb_planta_envase;

  localparam int TM = 4, TF = 8, TS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       M = 1'b0, EV = 1'b0, VE = 1'b0;
  logic       presenca, cheia, vedada, erro;
  logic [7:0] contador;
  logic [5:0] state;
  logic       presenca2, cheia2, vedada2, erro2;
  logic [1:0] contador2;
  logic [5:0] state2;

  int total = 0;
  int bad = 0;

  // Model: stage 0..5 = empty, moving, placed, filling, full, sealing;
  // prog = command-high cycles spent on the current phase (entry included).
  int m_stage, m_prog, m_cnt;
  bit m_err, m_ved;

  always #5 clk = ~clk;

  planta_envase dut (
    .clk(clk), .reset(reset), .M(M), .EV(EV), .VE(VE),
    .presenca(presenca), .cheia(cheia), .vedada(vedada),
    .contador(contador), .erro(erro), .state(state)
  );

  planta_envase #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .M(M), .EV(EV), .VE(VE),
    .presenca(presenca2), .cheia(cheia2), .vedada(vedada2),
    .contador(contador2), .erro(erro2), .state(state2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input int stg, input bit m, input bit ev, input bit ve);
    if (int'(m) + int'(ev) + int'(ve) > 1) return 1'b0;
    if (ev && !(stg == 2 || stg == 3)) return 1'b0;
    if (ve && !(stg == 4 || stg == 5)) return 1'b0;
    if (m && stg >= 3) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_stage = 0; m_prog = 0; m_cnt = 0; m_err = 0; m_ved = 0;
  endtask

  task automatic model_step(input bit m, input bit ev, input bit ve);
    m_ved = 0;
    if (m_err || !legal(m_stage, m, ev, ve)) begin
      m_err = 1;
      return;
    end
    case (m_stage)
      0: if (m) begin m_stage = 1; m_prog = 1; end
      1: if (m) begin
           m_prog++;
           if (m_prog == TM) begin m_stage = 2; m_prog = 0; end
         end
      2: if (ev) begin m_stage = 3; m_prog = 1; end
         else if (m) begin m_stage = 1; m_prog = 1; end
      3: if (ev) begin
           m_prog++;
           if (m_prog == TF) begin m_stage = 4; m_prog = 0; end
         end
      4: if (ve) begin m_stage = 5; m_prog = 1; end
      5: if (ve) begin
           m_prog++;
           if (m_prog == TS) begin m_stage = 0; m_prog = 0; m_cnt++; m_ved = 1; end
         end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":state"},    32'(state),     32'(1) << m_stage);
    chk({tag, ":presenca"}, 32'(presenca),  32'(m_stage >= 2));
    chk({tag, ":cheia"},    32'(cheia),     32'(m_stage >= 4));
    chk({tag, ":vedada"},   32'(vedada),    32'(m_ved));
    chk({tag, ":contador"}, 32'(contador),  32'(m_cnt % 256));
    chk({tag, ":erro"},     32'(erro),      32'(m_err));
    chk({tag, ":cnt2"},     32'(contador2), 32'(m_cnt % 4));
    chk({tag, ":erro2"},    32'(erro2),     32'(m_err));
  endtask

  task automatic step(input string tag, input bit m, input bit ev, input bit ve);
    M = m; EV = ev; VE = ve;
    @(posedge clk);
    model_step(m, ev, ve);
    #1;
    check_all(tag);
  endtask

  task automatic steps(input string tag, input int n, input bit m, input bit ev, input bit ve);
    for (int i = 0; i < n; i++) step(tag, m, ev, ve);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    M = 0; EV = 0; VE = 0;
    #1;
    model_reset();
    check_all(tag);
    #1 reset = 1'b1;
  endtask

  task automatic full_cycle(input string tag);
    steps(tag, TM, 1, 0, 0);
    steps(tag, TF, 0, 1, 0);
    steps(tag, TS, 0, 0, 1);
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset("rst0");
    steps("idle", 2, 0, 0, 0);

    steps("motor", TM, 1, 0, 0);
    chk("req040_presenca", 32'(presenca), 32'd1);
    chk("req040_state", 32'(state), 32'(6'b000100));

    steps("fill", TF, 0, 1, 0);
    steps("seal", TS, 0, 0, 1);
    chk("req041_vedada", 32'(vedada), 32'd1);
    chk("req041_contador", 32'(contador), 32'd1);
    chk("req041_presenca", 32'(presenca), 32'd0);
    step("after_seal", 0, 0, 0);
    chk("req041_pulse_end", 32'(vedada), 32'd0);

    steps("motor2", TM, 1, 0, 0);
    steps("fill5", 5, 0, 1, 0);
    steps("fillpause", 3, 0, 0, 0);
    steps("fill2", 2, 0, 1, 0);
    chk("req042_not_yet", 32'(cheia), 32'd0);
    step("fill_last", 0, 1, 0);
    chk("req042_cheia", 32'(cheia), 32'd1);
    steps("sealpause", 2, 0, 0, 0);
    step("seal_a", 0, 0, 1);
    step("sealhold", 0, 0, 0);
    step("seal_b", 0, 0, 1);

    for (int k = 0; k < 4; k++) full_cycle("wrap");
    chk("req043_cnt2", 32'(contador2), 32'd2);
    chk("req043_erro", 32'(erro2), 32'd0);

    step("pm0", 1, 0, 0);
    step("pm_pause", 0, 0, 0);
    steps("pm1", TM - 1, 1, 0, 0);
    step("discard", 1, 0, 0);
    steps("discard_move", TM - 1, 1, 0, 0);
    chk("req021_pos", 32'(presenca), 32'd1);
    full_cycle("post_discard_junk");

    for (int k = 0; k < 400; k++) begin
      int unsigned r;
      bit m, ev, ve;
      r = $urandom_range(0, 3);
      m = (r == 1); ev = (r == 2); ve = (r == 3);
      if (!legal(m_stage, m, ev, ve)) begin m = 0; ev = 0; ve = 0; end
      step("rand_legal", m, ev, ve);
    end

    do_reset("rst1");
    steps("m045", TM, 1, 0, 0);
    steps("f045", 3, 0, 1, 0);
    do_reset("req045_rst");
    chk("req045_state", 32'(state), 32'd1);
    steps("m045b", TM, 1, 0, 0);
    chk("req045_pos", 32'(state), 32'(6'b000100));

    do_reset("rst2");
    steps("m044", TM, 1, 0, 0);
    steps("f044", TF, 0, 1, 0);
    step("ilegal", 0, 1, 1);
    chk("req044_erro", 32'(erro), 32'd1);
    chk("req044_state", 32'(state), 32'(6'b010000));
    steps("frozen", 3, 0, 0, 1);
    chk("req044_frozen", 32'(state), 32'(6'b010000));
    do_reset("req033_clear");
    chk("req033_erro", 32'(erro), 32'd0);

    for (int k = 0; k < 8; k++) begin
      do_reset("rst_rand");
      for (int j = 0; j < 40; j++) begin
        int unsigned r;
        bit m, ev, ve;
        r = $urandom_range(0, 3);
        m = (r == 1); ev = (r == 2); ve = (r == 3);
        if ($urandom_range(0, 19) == 0) begin
          r = $urandom_range(0, 7);
          m = r[0]; ev = r[1]; ve = r[2];
        end
        step("rand_any", m, ev, ve);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
